// File: rtl/ps2_key_sequencer_pkg.sv
// ps2_pkg: shared PS/2 byte constants and the decoded event type.
package ps2_pkg;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;
  localparam logic [7:0] PS2_BAT   = 8'hAA;
  localparam logic [7:0] PS2_ERR0  = 8'h00;
  localparam logic [7:0] PS2_ERR1  = 8'hFF;
  localparam int PAUSE_SKIP = 7;
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;
endpackage

// File: rtl/ps2_key_sequencer_if.sv
// ps2_key_sequencer_if: receive-FIFO pop handshake and event-FIFO valid/ready bundle.
interface ps2_key_sequencer_if;
  logic       ps2_ready;
  logic [7:0] ps2_data;
  logic       ps2_nextdata_n;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  modport master (input ps2_ready, ps2_data, evt_ready,
                  output ps2_nextdata_n, evt_valid, evt_code, evt_ext, evt_break);
  modport slave (output ps2_ready, ps2_data, evt_ready,
                 input ps2_nextdata_n, evt_valid, evt_code, evt_ext, evt_break);
endinterface

// File: rtl/ps2_key_sequencer_evt_fifo.sv
// ps2_evt_fifo: small event FIFO; a push while full succeeds only if a pop happens in the same cycle.
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = $bits(ps2_evt_t)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         valid_o,
  output logic         drop_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic full, empty, do_push, do_pop;
  assign full    = cnt_q == (AW+1)'(DEPTH);
  assign empty   = cnt_q == '0;
  assign do_pop  = pop_i & ~empty;
  assign do_push = push_i & (~full | do_pop);
  assign drop_o  = push_i & ~do_push;
  assign valid_o = ~empty;
  assign dout_o  = empty ? '0 : mem_q[rd_q];
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/ps2_key_sequencer.sv
// ps2_key_sequencer: pops PS/2 bytes, parses E0/F0/E1 prefixes, filters typematic repeats,
// tracks the held key and queues make/break events.
module ps2_key_sequencer
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  ps2_key_sequencer_if.master bus,
  output logic               held,
  output logic [7:0]         held_code,
  output logic               held_ext,
  output logic [CNT_W-1:0]   press_cnt,
  output logic               overflow
);
  typedef enum logic {SAMPLE, WAIT} state_t;
  state_t st_q;
  logic nd_q, ext_q, brk_q, held_q, held_ext_q, overflow_q;
  logic [2:0] skip_q;
  logic [7:0] held_code_q, b;
  logic [CNT_W-1:0] press_q;
  logic consume, is_prefix, is_noise, is_code, match, rpt, push, drop, valid;
  ps2_evt_t evt, head;
  assign b         = bus.ps2_data;
  assign consume   = st_q == SAMPLE && bus.ps2_ready;
  assign is_prefix = b == PS2_EXT || b == PS2_BRK || b == PS2_PAUSE;
  assign is_noise  = b == PS2_ERR0 || b == PS2_ERR1 || b == PS2_BAT;
  assign is_code   = consume && skip_q == '0 && !is_prefix && !is_noise;
  assign evt       = {ext_q, brk_q, b};
  assign match     = held_q && b == held_code_q && ext_q == held_ext_q;
  assign rpt       = !brk_q && match;
  assign push      = is_code && !rpt;
  ps2_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push_i(push), .din_i(evt), .pop_i(bus.evt_ready),
    .dout_o(head), .valid_o(valid), .drop_o(drop)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      st_q        <= SAMPLE;
      nd_q        <= 1'b1;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      skip_q      <= '0;
      held_q      <= 1'b0;
      held_code_q <= '0;
      held_ext_q  <= 1'b0;
      press_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      st_q       <= consume ? WAIT : SAMPLE;
      nd_q       <= !consume;
      overflow_q <= overflow_q | drop;
      if (consume) begin
        if (skip_q != '0) skip_q <= skip_q - 1'b1;
        else if (b == PS2_EXT) ext_q <= 1'b1;
        else if (b == PS2_BRK) brk_q <= 1'b1;
        else begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
          if (b == PS2_PAUSE) skip_q <= 3'(PAUSE_SKIP);
        end
      end
      if (push && !brk_q) begin
        held_q      <= 1'b1;
        held_code_q <= b;
        held_ext_q  <= ext_q;
        press_q     <= press_q + 1'b1;
      end
      if (push && brk_q && match) held_q <= 1'b0;
    end
  end
  assign bus.ps2_nextdata_n = nd_q;
  assign bus.evt_valid      = valid;
  assign bus.evt_code       = head.code;
  assign bus.evt_ext        = head.ext;
  assign bus.evt_break      = head.brk;
  assign held               = held_q;
  assign held_code          = held_code_q;
  assign held_ext           = held_ext_q;
  assign press_cnt          = press_q;
  assign overflow           = overflow_q;
endmodule

// File: tb/tb_ps2_key_sequencer.sv
// tb_ps2_key_sequencer: receive-FIFO model feeding bytes, event scoreboard drained by a monitor.
module tb_ps2_key_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic held, held_ext, overflow;
  logic [7:0] held_code, press_cnt;
  int checks = 0;
  int errors = 0;
  logic [7:0] rxq[$];
  logic [9:0] expq[$];
  logic prev_nd = 1'b1;
  ps2_key_sequencer_if bus ();
  ps2_key_sequencer #(.DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .bus(bus), .held(held), .held_code(held_code),
    .held_ext(held_ext), .press_cnt(press_cnt), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  initial begin
    bus.ps2_ready = 1'b0;
    bus.ps2_data  = 8'h00;
    bus.evt_ready = 1'b1;
  end
  // receive-FIFO model: the head is dropped once the DUT has strobed nextdata_n
  always @(negedge clk) begin
    if (reset && !bus.ps2_nextdata_n && rxq.size() != 0) void'(rxq.pop_front());
    bus.ps2_ready = rxq.size() != 0;
    bus.ps2_data  = rxq.size() != 0 ? rxq[0] : 8'h00;
  end
  always @(negedge clk) begin
    if (reset && !bus.ps2_nextdata_n) check("strobe_b2b", prev_nd, 1);
    prev_nd = bus.ps2_nextdata_n;
    if (reset && bus.evt_valid && bus.evt_ready) begin
      if (expq.size() == 0) check("unexpected_evt", {bus.evt_ext, bus.evt_break, bus.evt_code}, 10'h3ff);
      else check("evt", {bus.evt_ext, bus.evt_break, bus.evt_code}, expq.pop_front());
    end
  end
  task automatic send(input logic [7:0] bytes[$]);
    @(posedge clk); #1;
    foreach (bytes[i]) rxq.push_back(bytes[i]);
  endtask
  task automatic expect_evt(input logic ext, input logic brk, input logic [7:0] code);
    expq.push_back({ext, brk, code});
  endtask
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!(rxq.size() == 0 && bus.ps2_nextdata_n && !(bus.evt_ready && bus.evt_valid)) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("timeout", 0, 1);
    @(negedge clk);
  endtask
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    rxq.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_nd", bus.ps2_nextdata_n, 1);
    check("rst_valid", bus.evt_valid, 0);
    check("rst_head", {bus.evt_ext, bus.evt_break, bus.evt_code}, 0);
    check("rst_held", {held, held_ext, held_code}, 0);
    check("rst_press", press_cnt, 0);
    check("rst_ovf", overflow, 0);
  endtask
  initial begin
    int n;
    do_reset();
    // basic make, with same-edge timing of event, counter and strobe
    expect_evt(0, 0, 8'h1C);
    send('{8'h1C});
    n = 0;
    @(negedge clk);
    while (bus.ps2_nextdata_n && n < 50) begin @(negedge clk); n++; end
    check("t1_strobe_seen", bus.ps2_nextdata_n, 0);
    check("t1_valid_same_edge", bus.evt_valid, 1);
    check("t1_held_same_edge", {held, held_code}, {1'b1, 8'h1C});
    check("t1_press_same_edge", press_cnt, 1);
    wait_idle();
    expect_evt(0, 1, 8'h1C);
    send('{8'hF0, 8'h1C});
    wait_idle();
    check("t1_held_after_brk", held, 0);
    check("t1_held_code_kept", held_code, 8'h1C);
    check("t1_press", press_cnt, 1);
    check("t1_leftover", expq.size(), 0);
    // typematic repeats
    do_reset();
    expect_evt(0, 0, 8'h1C);
    expect_evt(0, 1, 8'h1C);
    send('{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C});
    wait_idle();
    check("t2_press", press_cnt, 1);
    check("t2_held", held, 0);
    check("t2_leftover", expq.size(), 0);
    // extended keys
    do_reset();
    expect_evt(1, 0, 8'h75);
    expect_evt(1, 1, 8'h75);
    expect_evt(0, 0, 8'h75);
    send('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h75});
    wait_idle();
    check("t3_press", press_cnt, 2);
    check("t3_held", {held, held_ext, held_code}, {1'b1, 1'b0, 8'h75});
    check("t3_leftover", expq.size(), 0);
    // Pause sequence and noise bytes
    do_reset();
    expect_evt(0, 0, 8'h1C);
    send('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'hAA, 8'h1C});
    wait_idle();
    check("t4_press", press_cnt, 1);
    check("t4_held", {held, held_ext, held_code}, {1'b1, 1'b0, 8'h1C});
    check("t4_leftover", expq.size(), 0);
    // overflow with a stalled consumer
    do_reset();
    @(posedge clk); #1;
    bus.evt_ready = 1'b0;
    send('{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24});
    wait_idle();
    check("t5_ovf", overflow, 1);
    check("t5_press", press_cnt, 5);
    check("t5_held_code", held_code, 8'h24);
    check("t5_head_stable", {bus.evt_valid, bus.evt_code}, {1'b1, 8'h1C});
    foreach (expq[i]) check("t5_pre_leftover", 1, 0);
    expect_evt(0, 0, 8'h1C);
    expect_evt(0, 0, 8'h32);
    expect_evt(0, 0, 8'h21);
    expect_evt(0, 0, 8'h23);
    @(posedge clk); #1;
    bus.evt_ready = 1'b1;
    wait_idle();
    check("t5_drained", bus.evt_valid, 0);
    check("t5_ovf_sticky", overflow, 1);
    check("t5_leftover", expq.size(), 0);
    // reset with a break prefix pending
    do_reset();
    send('{8'hF0});
    wait_idle();
    check("t6_no_evt", bus.evt_valid, 0);
    do_reset();
    expect_evt(0, 0, 8'h1C);
    send('{8'h1C});
    wait_idle();
    check("t6_press", press_cnt, 1);
    check("t6_held", held, 1);
    check("t6_leftover", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
